// File: rtl/ticket_pkg.sv
// ticket_pkg: shared constants for the ticket issuer front-end.
// FSM encodings are plain localparams so legacy code comparing raw state
// values keeps working.
package ticket_pkg;

    // Default width of ticket numbers and service times.
    localparam int unsigned DT_SZ_DEF  = 4;

    // First valid ticket; 0 is reserved to mean "no customer".
    localparam int unsigned TICKET_MIN = 1;
    localparam int unsigned NO_CUST    = 0;

    // Output sequencer states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage : ticket_pkg

// File: rtl/ticket_fifo.sv
// ticket_fifo: small first-word-fall-through request buffer holding
// {ticket, service time} pairs. The caller must not push when full or pop
// when empty. Asynchronous active-high reset empties the buffer.
module ticket_fifo #(
    parameter int unsigned DT_SZ     = 4,
    parameter int unsigned REQ_DEPTH = 2,
    parameter int unsigned REQ_PTR_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [2*DT_SZ-1:0]     i_wr_data,
    input  logic                   i_pop,
    output logic [2*DT_SZ-1:0]     o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [REQ_PTR_W-1:0]   o_count
);

    logic [2*DT_SZ-1:0]   r_mem [REQ_DEPTH];
    logic [REQ_PTR_W-1:0] r_wr_ptr;
    logic [REQ_PTR_W-1:0] r_rd_ptr;
    logic [REQ_PTR_W-1:0] r_count;
    logic [REQ_PTR_W-1:0] w_wr_ptr_nxt;
    logic [REQ_PTR_W-1:0] w_rd_ptr_nxt;
    logic [2*DT_SZ-1:0]   w_rd_data;

    // Pointer advance with wrap modulo REQ_DEPTH.
    always_comb begin
        w_wr_ptr_nxt = (r_wr_ptr == REQ_PTR_W'(REQ_DEPTH - 1)) ? '0 : r_wr_ptr + REQ_PTR_W'(1);
        w_rd_ptr_nxt = (r_rd_ptr == REQ_PTR_W'(REQ_DEPTH - 1)) ? '0 : r_rd_ptr + REQ_PTR_W'(1);
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= w_wr_ptr_nxt;
            if (i_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + REQ_PTR_W'(1);
                2'b01:   r_count <= r_count - REQ_PTR_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < REQ_DEPTH; i++) begin
            if (i_push && (r_wr_ptr == REQ_PTR_W'(i))) r_mem[i] <= i_wr_data;
        end
    end

    // Head-of-queue read mux.
    always_comb begin
        w_rd_data = '0;
        for (int unsigned i = 0; i < REQ_DEPTH; i++) begin
            if (r_rd_ptr == REQ_PTR_W'(i)) w_rd_data = r_mem[i];
        end
    end

    assign o_rd_data = w_rd_data;
    assign o_count   = r_count;
    assign o_full    = (r_count == REQ_PTR_W'(REQ_DEPTH));
    assign o_empty   = (r_count == '0);

endmodule : ticket_fifo

// File: rtl/ticket_issuer.sv
// ticket_issuer: accepts arrival requests, issues sequential tickets
// (1..2^DT_SZ-1, wrapping to 1), buffers accepted customers and replays
// them as single-cycle out_valid pulses followed by GAP idle cycles.
// Optional build macro: TICKET_STATS_EN adds issued_cnt/reject_cnt outputs.
module ticket_issuer
    import ticket_pkg::*;
#(
    parameter int unsigned DT_SZ     = DT_SZ_DEF,
    parameter int unsigned REQ_DEPTH = 2,
    parameter int unsigned REQ_PTR_W = 2,
    parameter int unsigned GAP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [DT_SZ-1:0] req_time,
    input  logic             dn_ready,
    output logic             req_ack,
    output logic             req_rej,
    output logic [DT_SZ-1:0] ack_num,
    output logic             out_valid,
    output logic [DT_SZ-1:0] out_num,
    output logic [DT_SZ-1:0] out_time
`ifdef TICKET_STATS_EN
    ,
    output logic [7:0]       issued_cnt,
    output logic [7:0]       reject_cnt
`endif
);

    localparam int unsigned GAP_W = $clog2(GAP + 1);

    logic [1:0]           r_state;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [DT_SZ-1:0]     r_ticket;
    logic                 r_req_ack;
    logic                 r_req_rej;
    logic [DT_SZ-1:0]     r_ack_num;
    logic                 r_out_valid;
    logic [DT_SZ-1:0]     r_out_num;
    logic [DT_SZ-1:0]     r_out_time;

    logic                 w_full;
    logic                 w_empty;
    logic [REQ_PTR_W-1:0] w_count_unused;
    logic [2*DT_SZ-1:0]   w_head;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_gap_last;
    logic                 w_pop;
    logic [DT_SZ-1:0]     w_ticket_nxt;

    ticket_fifo #(
        .DT_SZ     (DT_SZ),
        .REQ_DEPTH (REQ_DEPTH),
        .REQ_PTR_W (REQ_PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_accept),
        .i_wr_data ({r_ticket, req_time}),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count_unused)
    );

    // Acceptance uses the registered full flag, so a same-edge pop never
    // frees a slot for the request. The last GAP cycle behaves like IDLE so
    // the output can run at one pulse per 1+GAP cycles.
    always_comb begin
        w_accept     = req && (req_time != '0) && !w_full;
        w_reject     = req && !w_accept;
        w_gap_last   = (r_state == ST_GAP) && (r_gap_cnt == GAP_W'(1));
        w_pop        = !w_empty && dn_ready && ((r_state == ST_IDLE) || w_gap_last);
        w_ticket_nxt = (r_ticket == '1) ? DT_SZ'(TICKET_MIN) : r_ticket + DT_SZ'(1);
    end

    // Ticket counter and accept/reject pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ticket  <= DT_SZ'(TICKET_MIN);
            r_req_ack <= 1'b0;
            r_req_rej <= 1'b0;
            r_ack_num <= DT_SZ'(NO_CUST);
        end else begin
            r_req_ack <= w_accept;
            r_req_rej <= w_reject;
            r_ack_num <= w_accept ? r_ticket : DT_SZ'(NO_CUST);
            if (w_accept) r_ticket <= w_ticket_nxt;
        end
    end

    // Output sequencer: IDLE -> SEND (one valid cycle) -> GAP (idle cycles).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gap_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_num   <= DT_SZ'(NO_CUST);
            r_out_time  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_num   <= DT_SZ'(NO_CUST);
            r_out_time  <= '0;
            if (w_pop) begin
                r_state     <= ST_SEND;
                r_out_valid <= 1'b1;
                r_out_num   <= w_head[2*DT_SZ-1:DT_SZ];
                r_out_time  <= w_head[DT_SZ-1:0];
            end else begin
                case (r_state)
                    ST_SEND: begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= GAP_W'(GAP);
                    end
                    ST_GAP: begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                        if (w_gap_last) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef TICKET_STATS_EN
    logic [7:0] r_issued_cnt;
    logic [7:0] r_reject_cnt;

    // Saturating pulse and reject counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued_cnt <= '0;
            r_reject_cnt <= '0;
        end else begin
            if (w_pop && (r_issued_cnt != '1))    r_issued_cnt <= r_issued_cnt + 8'd1;
            if (w_reject && (r_reject_cnt != '1)) r_reject_cnt <= r_reject_cnt + 8'd1;
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign reject_cnt = r_reject_cnt;
`endif

    assign req_ack   = r_req_ack;
    assign req_rej   = r_req_rej;
    assign ack_num   = r_ack_num;
    assign out_valid = r_out_valid;
    assign out_num   = r_out_num;
    assign out_time  = r_out_time;

endmodule : ticket_issuer

// File: tb/tb_ticket_issuer.sv
// tb_ticket_issuer: directed self-checking bench for ticket_issuer
// (DT_SZ=4, REQ_DEPTH=2, GAP=1). Define TICKET_STATS_EN to also exercise
// the statistics counters.
module tb_ticket_issuer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [3:0] req_time = 4'd0;
    logic       dn_ready = 1'b1;
    logic       req_ack;
    logic       req_rej;
    logic [3:0] ack_num;
    logic       out_valid;
    logic [3:0] out_num;
    logic [3:0] out_time;
`ifdef TICKET_STATS_EN
    logic [7:0] issued_cnt;
    logic [7:0] reject_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ticket_issuer #(
        .DT_SZ     (4),
        .REQ_DEPTH (2),
        .REQ_PTR_W (2),
        .GAP       (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_time  (req_time),
        .dn_ready  (dn_ready),
        .req_ack   (req_ack),
        .req_rej   (req_rej),
        .ack_num   (ack_num),
        .out_valid (out_valid),
        .out_num   (out_num),
        .out_time  (out_time)
`ifdef TICKET_STATS_EN
        ,
        .issued_cnt(issued_cnt),
        .reject_cnt(reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse applied away from the clock edge.
    task automatic do_reset();
        req = 1'b0;
        req_time = 4'd0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({req_ack, req_rej, ack_num, out_valid, out_num, out_time} !== 15'd0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h required 0", {req_ack, req_rej, ack_num, out_valid, out_num, out_time});
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({req_ack, req_rej, ack_num, out_valid, out_num, out_time} !== 15'd0) begin
            errors++;
            $display("FAIL reset_idle: outputs=%h required 0", {req_ack, req_rej, ack_num, out_valid, out_num, out_time});
        end
    endtask

    task automatic test_single();
        do_reset();
        dn_ready = 1'b1;
        req = 1'b1; req_time = 4'd8;
        step();
        req = 1'b0; req_time = 4'd0;
        checks++;
        if ({req_ack, req_rej, ack_num, out_valid} !== {1'b1, 1'b0, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_ack: ack=%b rej=%b num=%0d valid=%b required 1 0 1 0", req_ack, req_rej, ack_num, out_valid);
        end
        step();
        checks++;
        if ({req_ack, out_valid, out_num, out_time} !== {1'b0, 1'b1, 4'd1, 4'd8}) begin
            errors++;
            $display("FAIL single_pulse: ack=%b valid=%b num=%0d time=%0d required 0 1 1 8", req_ack, out_valid, out_num, out_time);
        end
        step();
        checks++;
        if ({out_valid, out_num, out_time} !== 9'd0) begin
            errors++;
            $display("FAIL single_gap: valid=%b num=%0d time=%0d required 0 0 0", out_valid, out_num, out_time);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_burst_overflow();
        logic [3:0] times [4];
        logic [5:0] want  [4];
        times = '{4'd1, 4'd5, 4'd2, 4'd3};
        want  = '{{2'b10, 4'd1}, {2'b10, 4'd2}, {2'b01, 4'd0}, {2'b01, 4'd0}};
        do_reset();
        dn_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; req_time = times[i];
            step();
            checks++;
            if ({req_ack, req_rej, ack_num} !== want[i]) begin
                errors++;
                $display("FAIL burst_req%0d: ack=%b rej=%b num=%0d required %b", i, req_ack, req_rej, ack_num, want[i]);
            end
        end
        req = 1'b0; req_time = 4'd0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_held: valid=%b required 0 while dn_ready=0", out_valid);
        end
        dn_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_num, out_time} !== {1'b1, 4'd1, 4'd1}) begin
            errors++;
            $display("FAIL burst_out1: valid=%b num=%0d time=%0d required 1 1 1", out_valid, out_num, out_time);
        end
        step();
        checks++;
        if ({out_valid, out_num} !== 5'd0) begin
            errors++;
            $display("FAIL burst_gap: valid=%b num=%0d required 0 0", out_valid, out_num);
        end
        step();
        checks++;
        if ({out_valid, out_num, out_time} !== {1'b1, 4'd2, 4'd5}) begin
            errors++;
            $display("FAIL burst_out2: valid=%b num=%0d time=%0d required 1 2 5", out_valid, out_num, out_time);
        end
        step();
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_drained: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_time_zero();
        do_reset();
        dn_ready = 1'b1;
        req = 1'b1; req_time = 4'd0;
        step();
        checks++;
        if ({req_ack, req_rej, ack_num} !== {1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL tzero_rej: ack=%b rej=%b num=%0d required 0 1 0", req_ack, req_rej, ack_num);
        end
        req_time = 4'd3;
        step();
        req = 1'b0; req_time = 4'd0;
        checks++;
        if ({req_ack, req_rej, ack_num, out_valid} !== {1'b1, 1'b0, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL tzero_next: ack=%b rej=%b num=%0d valid=%b required 1 0 1 0", req_ack, req_rej, ack_num, out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_num, out_time} !== {1'b1, 4'd1, 4'd3}) begin
            errors++;
            $display("FAIL tzero_pulse: valid=%b num=%0d time=%0d required 1 1 3", out_valid, out_num, out_time);
        end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        dn_ready = 1'b1;
        req = 1'b1; req_time = 4'd9;
        step();
        checks++;
        if ({req_ack, ack_num, out_valid} !== {1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_e0: ack=%b num=%0d valid=%b required 1 1 0", req_ack, ack_num, out_valid);
        end
        req_time = 4'd10;
        step();
        checks++;
        if ({req_ack, ack_num, out_valid, out_num, out_time} !== {1'b1, 4'd2, 1'b1, 4'd1, 4'd9}) begin
            errors++;
            $display("FAIL b2b_e1: ack=%b num=%0d valid=%b onum=%0d otime=%0d required 1 2 1 1 9", req_ack, ack_num, out_valid, out_num, out_time);
        end
        req_time = 4'd11;
        step();
        checks++;
        if ({req_ack, ack_num, out_valid} !== {1'b1, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL b2b_e2: ack=%b num=%0d valid=%b required 1 3 0", req_ack, ack_num, out_valid);
        end
        req_time = 4'd12;
        step();
        req = 1'b0; req_time = 4'd0;
        checks++;
        if ({req_ack, req_rej, ack_num, out_valid, out_num, out_time} !== {1'b0, 1'b1, 4'd0, 1'b1, 4'd2, 4'd10}) begin
            errors++;
            $display("FAIL b2b_e3: ack=%b rej=%b num=%0d valid=%b onum=%0d otime=%0d required 0 1 0 1 2 10", req_ack, req_rej, ack_num, out_valid, out_num, out_time);
        end
        step();
        checks++;
        if ({req_ack, req_rej, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_e4: ack=%b rej=%b valid=%b required 0 0 0", req_ack, req_rej, out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_num, out_time} !== {1'b1, 4'd3, 4'd11}) begin
            errors++;
            $display("FAIL b2b_e5: valid=%b num=%0d time=%0d required 1 3 11", out_valid, out_num, out_time);
        end
        step();
        step();
    endtask

    task automatic test_wrap();
        logic [3:0] exp_tk;
        do_reset();
        dn_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_tk = 4'((i % 15) + 1);
            req = 1'b1; req_time = 4'((i % 15) + 1);
            step();
            req = 1'b0; req_time = 4'd0;
            checks++;
            if ({req_ack, ack_num} !== {1'b1, exp_tk}) begin
                errors++;
                $display("FAIL wrap_ack%0d: ack=%b num=%0d required 1 %0d", i, req_ack, ack_num, exp_tk);
            end
            step();
            checks++;
            if ({out_valid, out_num} !== {1'b1, exp_tk} || out_num === 4'd0) begin
                errors++;
                $display("FAIL wrap_out%0d: valid=%b num=%0d required 1 %0d", i, out_valid, out_num, exp_tk);
            end
            step();
            step();
        end
    endtask

    task automatic test_reset_during_send();
        int stray;
        do_reset();
        dn_ready = 1'b0;
        req = 1'b1; req_time = 4'd7;
        step();
        req_time = 4'd6;
        step();
        req = 1'b0; req_time = 4'd0;
        dn_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_num, out_time} !== {1'b1, 4'd1, 4'd7}) begin
            errors++;
            $display("FAIL rsend_pulse: valid=%b num=%0d time=%0d required 1 1 7", out_valid, out_num, out_time);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ack, req_rej, ack_num, out_valid, out_num, out_time} !== 15'd0) begin
            errors++;
            $display("FAIL rsend_async: outputs=%h required 0", {req_ack, req_rej, ack_num, out_valid, out_num, out_time});
        end
        #1;
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rsend_flushed: %0d pulses after reset, required 0", stray);
        end
        req = 1'b1; req_time = 4'd4;
        step();
        req = 1'b0; req_time = 4'd0;
        checks++;
        if ({req_ack, ack_num} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL rsend_ticket: ack=%b num=%0d required 1 1", req_ack, ack_num);
        end
        step();
        step();
        step();
    endtask

`ifdef TICKET_STATS_EN
    task automatic test_stats();
        int pulses;
        do_reset();
        dn_ready = 1'b1;
        req = 1'b1; req_time = 4'd0;
        for (int i = 0; i < 300; i++) step();
        req = 1'b0;
        step();
        checks++;
        if (reject_cnt !== 8'd255) begin
            errors++;
            $display("FAIL stats_reject: reject_cnt=%0d required 255", reject_cnt);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            req = 1'b1; req_time = 4'd2;
            step();
            req = 1'b0; req_time = 4'd0;
            for (int j = 0; j < 4; j++) begin
                step();
                if (out_valid === 1'b1) pulses++;
            end
        end
        checks++;
        if (pulses !== 3 || issued_cnt !== 8'(pulses)) begin
            errors++;
            $display("FAIL stats_issued: issued_cnt=%0d pulses=%0d required 3", issued_cnt, pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst_overflow();
        test_time_zero();
        test_back_to_back();
        test_wrap();
        test_reset_during_send();
`ifdef TICKET_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ticket_issuer

// File: doc/ticket_issuer.md
# ticket_issuer

Front-end stage that feeds the bank-queue top block. It accepts customer arrival requests carrying a requested service time and assigns each accepted customer a sequential ticket number. Accepted customers are buffered in a small request queue and replayed as single-cycle `in_valid`/`in_num`/`in_time` pulses with idle gaps, the exact stimulus format the top block expects. Time-zero requests are rejected, and so are requests that find the buffer full.

## Interface
- DT_SZ, 4, width of ticket number and service time
- REQ_DEPTH, 2, request buffer entries (≥1)
- REQ_PTR_W, 2, pointer/count width, = floor(log2(REQ_DEPTH))+1
- GAP, 1, idle cycles forced after every output pulse (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req  in  1  arrival request, sampled each rising edge
- req_time  in  DT_SZ  requested service time, valid with req
- dn_ready  in  1  downstream may take a customer; tie 1 if unused
- req_ack  out  1  one-cycle pulse: request accepted
- req_rej  out  1  one-cycle pulse: request rejected
- ack_num  out  DT_SZ  ticket issued, valid with req_ack, else 0
- out_valid  out  1  connects to top in_valid
- out_num  out  DT_SZ  connects to top in_num
- out_time  out  DT_SZ  connects to top in_time

## Operation
- Reset values:
  - Outputs: all 0.
  - Internal state: FSM in IDLE, buffer empty, next ticket = 1.
  - Reset mid-pulse truncates the pulse immediately and discards all buffered entries.
- Ticket numbers:
  - Range 1..2^DT_SZ−1; 0 is reserved for "no customer".
  - After 2^DT_SZ−1 the next ticket is 1.
  - The counter advances only on acceptance.
- Acceptance, evaluated at each edge with req=1:
  - req_time==0: reject.
  - Buffer count==REQ_DEPTH, as seen before any same-edge pop: reject. A simultaneous pop does not free a slot for that request.
  - Otherwise: push {ticket, req_time} and pulse req_ack with ack_num=ticket.
- FSM:
  - IDLE: if buffer is non-empty and dn_ready=1, pop the head and go to SEND. Otherwise stay.
  - SEND: out_valid=1 with the popped num/time for exactly one cycle, then go to GAP with gap_cnt=GAP.
  - GAP: outputs forced to 0. Decrement gap_cnt each cycle; at 0 return to IDLE.
- dn_ready is checked only in IDLE; a pulse in progress is never cancelled.
- out_num/out_time read 0 whenever out_valid=0.
- Buffer order is FIFO; pointers wrap modulo REQ_DEPTH.

## Timing
- req sampled at edge E0:
  - req_ack/req_rej are high from E0 to E1.
  - If the buffer was empty and the FSM is in IDLE with dn_ready=1, out_valid is high from E1 to E2.
  - Minimum latency is 1 cycle; the top block samples the customer at E2.
- Maximum output rate is one customer per 1+GAP cycles. With GAP=1 the output is valid, idle, valid, idle, and so on.
- Push and pop on the same edge are both legal when the buffer is not full.
- Back-to-back requests are accepted every cycle until the buffer is full.

## Configuration
- TICKET_STATS_EN:
  - Defined: adds outputs issued_cnt[7:0], which increments on each out_valid pulse, and reject_cnt[7:0], which increments on each req_rej.
  - Both counters saturate at 255 and clear on rst.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package ticket_pkg holds:
  - FSM state encoding: IDLE, SEND, GAP.
  - TICKET_MIN=1 and the reserved NO_CUST=0 constant.
  - The shared DT_SZ default.
- Sub-module ticket_fifo:
  - Parameterised by DT_SZ, REQ_DEPTH and REQ_PTR_W; stores 2·DT_SZ-bit entries.
  - Provides full/empty flags and a registered count.
  - Uses the same asynchronous active-high reset.

## Test plan
- Single request: reset, then req with time=8 → ack_num=1, then out_valid one cycle later with num=1/time=8, then 0 for 1 cycle.
- Burst overflow: req times 1,5,2,3 on four consecutive cycles with dn_ready=0 → acks for tickets 1,2; the last two requests are rejected (buffer full). With dn_ready=1, tickets 1 then 2 go out as pulses spaced exactly 2 cycles apart.
- Time zero: req with time=0 → req_rej; the next valid request still receives ticket 1.
- Wrap-around: issue 15 tickets → the 16th accepted request gets ticket 1, and 0 never appears on out_num.
- Reset during SEND: assert rst while out_valid=1 → all outputs go to 0 asynchronously and the buffer empties. The next request gets ticket 1.
- Stats (TICKET_STATS_EN): 300 rejected requests → reject_cnt holds at 255, and issued_cnt matches the out_valid pulse count.
